enemy_bullet_gen: RTL and testbench
===================================

# enemy_bullet_gen

Spawns, moves and retires enemy bullets for the shooter game. It is the producer side of the enemy-bullet interface: it fires from the enemy plane position on a cooldown and advances each bullet downward once per frame tick. It frees a slot when the bullet leaves the screen or when the player-hit judge returns a hit-clear for it. Its per-slot position/enable outputs feed the hit judge and the VGA renderer.

## Interface
Parameters:
- N_SLOTS, 4, number of concurrent enemy bullets (1..8)
- FIRE_PERIOD, 30, ticks between shots (≥1)
- SPEED, 4, pixels moved down per tick (1..31)
- X_OFF, 20, spawn x offset from e_x
- Y_OFF, 40, spawn y offset from e_y

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- tick  in  1  one-clk frame strobe; all movement and cooldown advance only on tick
- e_x  in  10  enemy plane x (top-left)
- e_y  in  10  enemy plane y (top-left)
- enemy_en  in  1  1 = enemy plane alive
- hit_clr  in  N_SLOTS  one-clk pulse per slot from hit judge; retire that bullet
- eb_x  out  N_SLOTS*10  packed bullet x, slot i at [10i+9:10i]
- eb_y  out  N_SLOTS*10  packed bullet y
- eb_en  out  N_SLOTS  1 = slot holds a live bullet
- fire  out  1  one-clk pulse when a bullet spawns
- fire_slot  out  3  slot index of the last spawn
- active_cnt  out  4  number of live bullets (popcount of eb_en)

## Operation
- Cooldown counter cd (0..FIRE_PERIOD-1) increments on each tick while enemy_en=1; enemy_en=0 forces cd=0, and no spawn occurs.
- Shot due when tick && enemy_en && cd==FIRE_PERIOD-1. If any slot is free (registered eb_en[i]=0), spawn into the lowest free index, pulse fire, load fire_slot, and set cd=0.
- Shot due with no free slot: cd holds at FIRE_PERIOD-1, and the shot retries on every subsequent tick until a slot frees.
- Spawn position: x = min(e_x+X_OFF, SCREEN_W-1), y = e_y+Y_OFF. Both are computed 11 bits wide. If the sum of y is ≥ SCREEN_H, the spawn is suppressed and cd still resets.
- Movement: on tick, each live slot not spawning this cycle computes y_next = y+SPEED (11 bits). If y_next ≥ SCREEN_H, eb_en clears and y is held; otherwise y ← y_next. x never changes after spawn.
- hit_clr[i]=1 clears eb_en[i] next clk, regardless of tick. hit_clr on a slot that is already free is ignored.
- Priority per slot, highest first: hit_clr > retire-at-bottom > move. Spawn only targets slots whose eb_en was 0 before the edge. A slot cleared this cycle is not spawnable until the following cycle.
- A freshly spawned bullet does not move on its spawn tick.
- active_cnt is registered and reflects eb_en after the same edge.

## Timing
- All outputs are registered. Effects of tick, hit_clr and enemy_en appear one clk after the sampling edge.
- Reset values: eb_en=0, eb_x=0, eb_y=0, fire=0, fire_slot=0, active_cnt=0, cd=0.
- Assertion of rst mid-flight kills all bullets immediately (asynchronous). The first shot after release needs a full FIRE_PERIOD ticks.
- fire is high for exactly one clk per spawn. fire=0 on all non-tick cycles.
- Back-to-back ticks (tick held high) are legal; each clk with tick=1 counts as one tick.

## Structure
- Shared package game_pkg holds:
  - SCREEN_W=640 and SCREEN_H=480
  - coord_t as a 10-bit logic type
  - the packing macro/function for slot-indexed buses
- One sub-module, eb_slot, holds one bullet's x/y/en registers, its move/retire/clear logic and load port. It is instantiated N_SLOTS times.
- Top level holds the cooldown counter, the lowest-free priority encoder, spawn arithmetic and the popcount.

## Test plan
- Reset, then enemy_en=1 with e_x=100, e_y=50 and 30 ticks -> fire on tick 30, slot 0 at (120,90), eb_en=0001.
- One live bullet at y=90 and 5 more ticks -> y=110. At y=476, the next tick -> eb_en[0]=0 with y held at 476.
- 4 slots live with the shot due -> no fire and cd holds. hit_clr=0010 -> eb_en[1]=0 next clk; the next tick spawns into slot 1 with fire_slot=1.
- hit_clr[2] and tick on the same clk while slot 2 is live -> slot 2 cleared, with no movement applied.
- enemy_en dropped at cd=20, then raised again -> cd restarts at 0, and the first shot comes 30 ticks later.
- e_x=630 -> spawn x clamps to 639. e_y=445 -> spawn suppressed, fire=0, cd=0.
- rst pulsed with 3 bullets live -> all outputs return to 0 immediately, and active_cnt=0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared screen geometry, coordinate types and slot-bus packing helper for the shooter game.
package game_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned COORD_W  = 10;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COORD_W:0]   coord_wide_t;

  typedef enum logic [1:0] {
    CD_KEEP,
    CD_INC,
    CD_HOLD,
    CD_CLEAR
  } cd_op_t;

  // LSB position of slot i inside a packed slot-indexed coordinate bus.
  function automatic int unsigned slot_lsb(input int unsigned i);
    return i * COORD_W;
  endfunction

endpackage

// File: rtl/eb_slot.sv
// One enemy bullet: position/enable registers with hit-clear, spawn load, move and bottom retire.
module eb_slot
  import game_pkg::*;
#(
  parameter int unsigned SPEED = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   tick,
  input  logic   clr,
  input  logic   load,
  input  coord_t load_x,
  input  coord_t load_y,
  output coord_t x,
  output coord_t y,
  output logic   en,
  output logic   en_nxt
);

  coord_wide_t y_step;
  coord_t      x_nxt;
  coord_t      y_nxt;

  always_comb begin
    y_step = {1'b0, y} + coord_wide_t'(SPEED);
    x_nxt  = x;
    y_nxt  = y;
    en_nxt = en;
    // Load is only ever steered at a slot that was free before the edge, so it never competes with move.
    if (clr && en) begin
      en_nxt = 1'b0;
    end else if (load && !en) begin
      en_nxt = 1'b1;
      x_nxt  = load_x;
      y_nxt  = load_y;
    end else if (tick && en) begin
      if (y_step >= coord_wide_t'(SCREEN_H)) begin
        en_nxt = 1'b0;
      end else begin
        y_nxt = y_step[COORD_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x  <= '0;
      y  <= '0;
      en <= 1'b0;
    end else begin
      x  <= x_nxt;
      y  <= y_nxt;
      en <= en_nxt;
    end
  end

endmodule

// File: rtl/enemy_bullet_gen.sv
// Enemy bullet producer: fire cooldown, lowest-free slot allocation, spawn position and live count.
module enemy_bullet_gen
  import game_pkg::*;
#(
  parameter int unsigned N_SLOTS     = 4,
  parameter int unsigned FIRE_PERIOD = 30,
  parameter int unsigned SPEED       = 4,
  parameter int unsigned X_OFF       = 20,
  parameter int unsigned Y_OFF       = 40
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic [9:0]             e_x,
  input  logic [9:0]             e_y,
  input  logic                   enemy_en,
  input  logic [N_SLOTS-1:0]     hit_clr,
  output logic [N_SLOTS*10-1:0]  eb_x,
  output logic [N_SLOTS*10-1:0]  eb_y,
  output logic [N_SLOTS-1:0]     eb_en,
  output logic                   fire,
  output logic [2:0]             fire_slot,
  output logic [3:0]             active_cnt
);

  localparam int unsigned CD_W = (FIRE_PERIOD > 1) ? $clog2(FIRE_PERIOD) : 1;
  localparam logic [CD_W-1:0] CD_LAST = CD_W'(FIRE_PERIOD - 1);

  logic [CD_W-1:0]    cd;
  logic [CD_W-1:0]    cd_nxt;
  cd_op_t             cd_op;
  logic               shot_due;
  logic               do_spawn;
  logic               any_free;
  logic [2:0]         free_idx;
  coord_wide_t        sum_x;
  coord_wide_t        sum_y;
  coord_t             spawn_x;
  coord_t             spawn_y;
  logic               y_ok;
  logic [N_SLOTS-1:0] load;
  logic [N_SLOTS-1:0] en_nxt;
  logic [3:0]         cnt_nxt;

  always_comb begin
    sum_x   = {1'b0, e_x} + coord_wide_t'(X_OFF);
    sum_y   = {1'b0, e_y} + coord_wide_t'(Y_OFF);
    spawn_x = (sum_x >= coord_wide_t'(SCREEN_W)) ? coord_t'(SCREEN_W - 1) : sum_x[COORD_W-1:0];
    spawn_y = sum_y[COORD_W-1:0];
    y_ok    = (sum_y < coord_wide_t'(SCREEN_H));
  end

  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      if (!eb_en[i] && !any_free) begin
        any_free = 1'b1;
        free_idx = 3'(i);
      end
    end
  end

  assign shot_due = tick && enemy_en && (cd == CD_LAST);
  assign do_spawn = shot_due && y_ok && any_free;

  // A due shot with nowhere to go keeps cd parked so it retries each tick; a suppressed one still rearms.
  always_comb begin
    cd_op = CD_KEEP;
    if (!enemy_en) begin
      cd_op = CD_CLEAR;
    end else if (shot_due) begin
      cd_op = (!y_ok || any_free) ? CD_CLEAR : CD_HOLD;
    end else if (tick) begin
      cd_op = CD_INC;
    end
  end

  always_comb begin
    cd_nxt = cd;
    unique case (cd_op)
      CD_CLEAR: cd_nxt = '0;
      CD_INC:   cd_nxt = cd + 1'b1;
      CD_HOLD:  cd_nxt = cd;
      default:  cd_nxt = cd;
    endcase
  end

  for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
    coord_t slot_x;
    coord_t slot_y;

    assign load[i] = do_spawn && (free_idx == 3'(i));

    eb_slot #(
      .SPEED (SPEED)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .clr    (hit_clr[i]),
      .load   (load[i]),
      .load_x (spawn_x),
      .load_y (spawn_y),
      .x      (slot_x),
      .y      (slot_y),
      .en     (eb_en[i]),
      .en_nxt (en_nxt[i])
    );

    assign eb_x[slot_lsb(i) +: COORD_W] = slot_x;
    assign eb_y[slot_lsb(i) +: COORD_W] = slot_y;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      cnt_nxt = cnt_nxt + 4'(en_nxt[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cd         <= '0;
      fire       <= 1'b0;
      fire_slot  <= '0;
      active_cnt <= '0;
    end else begin
      cd         <= cd_nxt;
      fire       <= do_spawn;
      active_cnt <= cnt_nxt;
      if (do_spawn) begin
        fire_slot <= free_idx;
      end
    end
  end

endmodule

// File: tb/tb_enemy_bullet_gen.sv
// Directed bench for enemy_bullet_gen: a default instance plus a short-cooldown instance for full-slot cases.
module tb_enemy_bullet_gen;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic [9:0]    e_x = 10'd100;
  logic [9:0]    e_y = 10'd50;
  logic          enemy_en = 1'b0;
  logic          enemy_en_f = 1'b0;
  logic [N-1:0]  hit_clr = '0;
  logic [N-1:0]  hit_clr_f = '0;

  logic [N*10-1:0] eb_x, eb_y, eb_x_f, eb_y_f;
  logic [N-1:0]    eb_en, eb_en_f;
  logic            fire, fire_f;
  logic [2:0]      fire_slot, fire_slot_f;
  logic [3:0]      active_cnt, active_cnt_f;

  int checks = 0;
  int errors = 0;
  logic fire_seen, fire_f_seen;

  always #5 clk = ~clk;

  enemy_bullet_gen dut (
    .clk(clk), .rst(rst), .tick(tick), .e_x(e_x), .e_y(e_y), .enemy_en(enemy_en),
    .hit_clr(hit_clr), .eb_x(eb_x), .eb_y(eb_y), .eb_en(eb_en), .fire(fire),
    .fire_slot(fire_slot), .active_cnt(active_cnt)
  );

  enemy_bullet_gen #(.FIRE_PERIOD(3)) dut_f (
    .clk(clk), .rst(rst), .tick(tick), .e_x(e_x), .e_y(e_y), .enemy_en(enemy_en_f),
    .hit_clr(hit_clr_f), .eb_x(eb_x_f), .eb_y(eb_y_f), .eb_en(eb_en_f), .fire(fire_f),
    .fire_slot(fire_slot_f), .active_cnt(active_cnt_f)
  );

  function automatic logic [9:0] fld(input logic [N*10-1:0] b, input int i);
    return b[i*10 +: 10];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Back-to-back ticks starting at a negedge; returns at a negedge with the last tick's effects visible.
  task automatic ticks(input int n);
    fire_seen   = 1'b0;
    fire_f_seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      tick = 1'b1;
      @(negedge clk);
      fire_seen   = fire_seen | fire;
      fire_f_seen = fire_f_seen | fire_f;
    end
    tick = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    check("rst_en", eb_en, 0);
    check("rst_cnt", active_cnt, 0);
    check("rst_fire", fire, 0);
    check("rst_x", eb_x, 0);
    check("rst_y", eb_y, 0);
    rst = 1'b0;
    step();

    // First shot after 30 ticks
    enemy_en = 1'b1;
    ticks(29);
    check("early_fire", fire_seen, 0);
    check("early_en", eb_en, 0);
    ticks(1);
    check("fire30", fire, 1);
    check("fire30_slot", fire_slot, 0);
    check("fire30_en", eb_en, 4'b0001);
    check("fire30_x", fld(eb_x, 0), 120);
    check("fire30_y", fld(eb_y, 0), 90);
    check("fire30_cnt", active_cnt, 1);
    step();
    check("fire_pulse", fire, 0);

    ticks(5);
    check("move_y", fld(eb_y, 0), 110);

    hit_clr = 4'b0001;
    step();
    hit_clr = '0;
    check("clr_en", eb_en, 0);
    check("clr_cnt", active_cnt, 0);
    check("clr_yhold", fld(eb_y, 0), 110);

    // Bottom retire: spawn at y=92 so it lands exactly on 476
    e_y = 10'd52;
    ticks(25);
    check("spawn92", fire, 1);
    check("spawn92_y", fld(eb_y, 0), 92);
    enemy_en = 1'b0;
    ticks(96);
    check("y476", fld(eb_y, 0), 476);
    check("y476_en", eb_en, 4'b0001);
    ticks(1);
    check("retire_en", eb_en, 0);
    check("retire_y", fld(eb_y, 0), 476);
    check("retire_cnt", active_cnt, 0);

    // enemy_en drop at cd=20 restarts the cooldown
    enemy_en = 1'b1;
    e_y = 10'd50;
    ticks(20);
    enemy_en = 1'b0;
    step();
    enemy_en = 1'b1;
    ticks(29);
    check("restart_early", fire_seen, 0);
    ticks(1);
    check("restart_fire", fire, 1);
    check("restart_x", fld(eb_x, 0), 120);

    e_x = 10'd630;
    ticks(30);
    check("clamp_fire", fire, 1);
    check("clamp_slot", fire_slot, 1);
    check("clamp_x", fld(eb_x, 1), 639);
    check("clamp_y", fld(eb_y, 1), 90);

    e_y = 10'd445;
    ticks(30);
    check("supp_fire", fire_seen, 0);
    check("supp_en", eb_en, 4'b0011);
    e_x = 10'd100;
    e_y = 10'd50;
    ticks(29);
    check("supp_cd0", fire_seen, 0);
    ticks(1);
    check("after_supp_fire", fire, 1);
    check("after_supp_slot", fire_slot, 2);
    check("after_supp_en", eb_en, 4'b0111);
    check("y0_450", fld(eb_y, 0), 450);
    check("y1_330", fld(eb_y, 1), 330);

    // Asynchronous reset mid-cycle with 3 live bullets
    #2;
    rst = 1'b1;
    #1;
    check("arst_en", eb_en, 0);
    check("arst_cnt", active_cnt, 0);
    check("arst_fire", fire, 0);
    check("arst_xy", {eb_x, eb_y}, 0);
    step();
    rst = 1'b0;
    step();
    ticks(29);
    check("post_rst_early", fire_seen, 0);
    ticks(1);
    check("post_rst_fire", fire, 1);
    check("post_rst_slot", fire_slot, 0);
    enemy_en = 1'b0;

    // Short-cooldown instance: fill all slots, blocked shot, hit_clr and clear-vs-move
    enemy_en_f = 1'b1;
    ticks(3);
    check("f_s0", fire_f, 1);
    check("f_s0_slot", fire_slot_f, 0);
    ticks(3);
    check("f_s1_slot", fire_slot_f, 1);
    ticks(3);
    check("f_s2_slot", fire_slot_f, 2);
    ticks(3);
    check("f_s3_slot", fire_slot_f, 3);
    check("f_full_en", eb_en_f, 4'b1111);
    check("f_full_cnt", active_cnt_f, 4);
    ticks(4);
    check("f_blocked", fire_f_seen, 0);
    check("f_blocked_en", eb_en_f, 4'b1111);
    hit_clr_f = 4'b0010;
    step();
    hit_clr_f = '0;
    check("f_clr1_en", eb_en_f, 4'b1101);
    check("f_clr1_cnt", active_cnt_f, 3);
    ticks(1);
    check("f_retry_fire", fire_f, 1);
    check("f_retry_slot", fire_slot_f, 1);
    check("f_retry_en", eb_en_f, 4'b1111);
    check("f_retry_y1", fld(eb_y_f, 1), 90);
    hit_clr_f = 4'b0100;
    ticks(1);
    hit_clr_f = '0;
    check("f_clr2_en", eb_en_f, 4'b1011);
    check("f_clr2_yhold", fld(eb_y_f, 2), 122);
    check("f_clr2_y1", fld(eb_y_f, 1), 94);
    check("f_clr2_cnt", active_cnt_f, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
